regfile_write_arbiter: RTL

Shares the register file's single write port among several writeback sources, for example ALU result, load return and multiply/divide result. Each cycle it grants one requester by round-robin and registers the selected write onto the `reg_write` / `number` / `write_data` signals that drive `register_write`. It also keeps a pending-write scoreboard so issue logic can detect RAW hazards on registers whose writeback has not yet committed.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the writeback path.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;
  localparam int WORD_W    = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  // One writeback request: destination register and value.
  typedef struct packed {
    reg_idx_t number;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// advances the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_next;
  logic           found;

  // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; first valid requester wins.
  // Reset suppresses every grant so nothing can be accepted that cycle.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx] && !reset) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

  // Pointer moves to the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    if (int'(grant_id) == NREQ - 1) ptr_next = '0;
    else                            ptr_next = grant_id + IDW'(1);
  end

  // Pointer register; holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= '0;
    else if (accept) rr_ptr <= ptr_next;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NREQ writeback sources and
// tracks claimed-but-uncommitted destinations for RAW hazard detection.
//
// Handshake: a write transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is a combinational function of
// req_valid and the round-robin pointer, so a requester must never derive
// req_valid from req_ready; once raised, req_valid should stay high with
// stable number/data until the transfer happens.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = WORD_W,
  parameter int AW   = REG_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][AW-1:0]  req_number,
  input  logic [NREQ-1:0][DW-1:0]  req_data,
  input  logic                     claim_valid,
  input  logic [AW-1:0]            claim_number,
  output logic                     reg_write,
  output logic [AW-1:0]            number,
  output logic [DW-1:0]            write_data,
  output logic [(2**AW)-1:0]       pending
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_id;
  logic                accept;
  logic [AW-1:0]       win_number;
  logic [DW-1:0]       win_data;
  logic [(2**AW)-1:0]  pending_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready  = grant;
  assign accept     = |(req_valid & grant);
  assign win_number = req_number[grant_id];
  assign win_data   = req_data[grant_id];

  // Output register: load the winner; writes to r0 load but stay disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      number     <= '0;
      write_data <= '0;
    end else if (accept) begin
      reg_write  <= (win_number != '0);
      number     <= win_number;
      write_data <= win_data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // Scoreboard next state: commit clears, claim sets afterwards so a claim
  // on the register being written in the same cycle leaves it pending.
  always_comb begin
    pending_next = pending;
    if (accept)      pending_next[win_number]   = 1'b0;
    if (claim_valid) pending_next[claim_number] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Scoreboard register; claims during reset are dropped.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

endmodule
